opti_divider: RTL and testbench

//   Q2.22 / Q2.22 signed fixed-point divider, iterative radix-2 restoring, one quotient bit per cycle.

---
 rtl/opti_divider.sv | 128 ++++++++++++
 tb/tb_opti_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/opti_divider.sv
// Signed Q2.22 / Q2.22 divider: restoring radix-2, one quotient bit per cycle,
// truncation toward zero with saturation to the Q2.22 range.
module opti_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   output logic        in_ready,
   input  logic [23:0] a,
   input  logic [23:0] b,
   output logic        valid_out,
   input  logic        out_ready,
   output logic [23:0] p,
   output logic        div_zero,
   output logic        sat
);
   localparam int          NUM_W = 46;
   localparam int          ITERS = 46;
   localparam logic [23:0] Q_MAX = 24'h7FFFFF;
   localparam logic [23:0] Q_MIN = 24'h800000;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state_reg;
   logic               sign_reg;
   logic [NUM_W-1:0]   num_reg;
   logic [23:0]        abs_b_reg;
   logic [24:0]        rem_reg;
   logic [NUM_W-1:0]   q_reg;
   logic [5:0]         cnt_reg;
   logic [23:0]        p_reg;
   logic               valid_out_reg;
   logic               div_zero_reg;
   logic               sat_reg;

   logic [23:0]        abs_a;
   logic [23:0]        abs_b;
   logic [24:0]        rem_shift;
   logic               rem_ge;
   logic [24:0]        rem_next;
   logic [NUM_W-1:0]   q_next;
   logic [23:0]        p_next;
   logic               sat_next;

   assign abs_a     = a[23] ? 24'(~a + 24'd1) : a;
   assign abs_b     = b[23] ? 24'(~b + 24'd1) : b;
   assign in_ready  = (state_reg == IDLE);
   assign valid_out = valid_out_reg;
   assign p         = p_reg;
   assign div_zero  = div_zero_reg;
   assign sat       = sat_reg;

   // The remainder stays below |b| < 2^24, so 25 bits hold the shifted value.
   always_comb begin
      rem_shift       = {rem_reg[23:0], num_reg[cnt_reg]};
      rem_ge          = (rem_shift >= {1'b0, abs_b_reg});
      rem_next        = rem_ge ? (rem_shift - {1'b0, abs_b_reg}) : rem_shift;
      q_next          = q_reg;
      q_next[cnt_reg] = rem_ge;

      sat_next = 1'b0;
      p_next   = sign_reg ? 24'(~q_next[23:0] + 24'd1) : q_next[23:0];
      if (!sign_reg && (q_next > 46'h7FFFFF)) begin
         p_next   = Q_MAX;
         sat_next = 1'b1;
      end else if (sign_reg && (q_next > 46'h800000)) begin
         p_next   = Q_MIN;
         sat_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         sign_reg      <= 1'b0;
         num_reg       <= '0;
         abs_b_reg     <= '0;
         rem_reg       <= '0;
         q_reg         <= '0;
         cnt_reg       <= '0;
         p_reg         <= '0;
         valid_out_reg <= 1'b0;
         div_zero_reg  <= 1'b0;
         sat_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (valid_in) begin
                  if (b == 24'd0) begin
                     p_reg         <= a[23] ? Q_MIN : Q_MAX;
                     div_zero_reg  <= 1'b1;
                     sat_reg       <= 1'b1;
                     valid_out_reg <= 1'b1;
                     state_reg     <= DONE;
                  end else begin
                     sign_reg  <= a[23] ^ b[23];
                     num_reg   <= {abs_a, 22'd0};
                     abs_b_reg <= abs_b;
                     cnt_reg   <= 6'(ITERS - 1);
                     rem_reg   <= '0;
                     q_reg     <= '0;
                     state_reg <= CALC;
                  end
               end
            end
            CALC: begin
               rem_reg <= rem_next;
               q_reg   <= q_next;
               cnt_reg <= cnt_reg - 6'd1;
               // Last bit goes straight into the output register.
               if (cnt_reg == 6'd0) begin
                  p_reg         <= p_next;
                  sat_reg       <= sat_next;
                  div_zero_reg  <= 1'b0;
                  valid_out_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  valid_out_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_opti_divider.sv
// Self-checking bench for opti_divider: directed and random operands checked
// against an arithmetic reference (integer division, then clamp).
module tb_opti_divider;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic        out_ready = 1'b0;
   logic [23:0] a = '0;
   logic [23:0] b = '0;
   logic        in_ready;
   logic        valid_out;
   logic [23:0] p;
   logic        div_zero;
   logic        sat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   opti_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .valid_out (valid_out),
      .out_ready (out_ready),
      .p         (p),
      .div_zero  (div_zero),
      .sat       (sat)
   );

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: real-valued quotient truncated toward zero, then clamped.
   function automatic void model(input logic [23:0] ta, input logic [23:0] tbv,
                                 output logic [23:0] ep, output logic es, output logic ez);
      longint na, nb, mag, r;
      na = longint'($signed(ta));
      nb = longint'($signed(tbv));
      ez = (nb == 0);
      if (nb == 0) begin
         es = 1'b1;
         ep = (na < 0) ? 24'h800000 : 24'h7FFFFF;
      end else begin
         mag = ((na < 0 ? -na : na) * 64'sd4194304) / (nb < 0 ? -nb : nb);
         r   = ((na < 0) != (nb < 0)) ? -mag : mag;
         if (r > 64'sd8388607) begin
            ep = 24'h7FFFFF;
            es = 1'b1;
         end else if (r < -64'sd8388608) begin
            ep = 24'h800000;
            es = 1'b1;
         end else begin
            ep = 24'(r);
            es = 1'b0;
         end
      end
   endfunction

   task automatic run_op(input logic [23:0] ta, input logic [23:0] tbv, input bit do_release);
      logic [23:0] ep;
      logic        es, ez;
      int          lat, exp_lat;
      model(ta, tbv, ep, es, ez);
      exp_lat = (tbv == 24'd0) ? 0 : 46;
      @(negedge clk);
      check("in_ready_idle", 48'(in_ready), 48'h1);
      a = ta;
      b = tbv;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      a = 24'($urandom);
      b = 24'($urandom);
      check("in_ready_busy", 48'(in_ready), 48'h0);
      lat = 0;
      while (!valid_out && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 48'(lat), 48'(exp_lat));
      check("p", 48'(p), 48'(ep));
      check("sat", 48'(sat), 48'(es));
      check("div_zero", 48'(div_zero), 48'(ez));
      $display("op a=%h b=%h -> p=%h sat=%b div_zero=%b latency=%0d (ref p=%h sat=%b)",
               ta, tbv, p, sat, div_zero, lat, ep, es);
      if (do_release) begin
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         check("valid_out_drop", 48'(valid_out), 48'h0);
         check("in_ready_after", 48'(in_ready), 48'h1);
      end
   endtask

   initial begin
      logic [23:0] held_p;
      logic [23:0] rb;
      int          seen;

      #1;
      check("rst_valid_out", 48'(valid_out), 48'h0);
      check("rst_p", 48'(p), 48'h0);
      check("rst_in_ready", 48'(in_ready), 48'h1);
      check("rst_sat", 48'(sat), 48'h0);
      check("rst_div_zero", 48'(div_zero), 48'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_op(24'h200000, 24'h400000, 1'b1);
      run_op(24'h400000, 24'h100000, 1'b1);
      run_op(24'hC00000, 24'h100000, 1'b1);
      run_op(24'hC00000, 24'h600000, 1'b1);
      run_op(24'h800000, 24'h400000, 1'b1);
      run_op(24'h100000, 24'h000000, 1'b1);
      run_op(24'hF00000, 24'h000000, 1'b1);
      run_op(24'h000000, 24'hC00000, 1'b1);
      run_op(24'h7FFFFF, 24'h800000, 1'b1);

      // Backpressure: result must hold while out_ready stays low.
      run_op(24'hC00000, 24'h600000, 1'b0);
      held_p = p;
      repeat (10) begin
         @(negedge clk);
         valid_in = 1'b1;
         a = 24'($urandom);
         b = 24'($urandom);
         @(posedge clk);
         #1;
         check("bp_p", 48'(p), 48'(held_p));
         check("bp_valid_out", 48'(valid_out), 48'h1);
         check("bp_in_ready", 48'(in_ready), 48'h0);
      end
      @(negedge clk);
      valid_in = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_release", 48'(valid_out), 48'h0);
      run_op(24'h200000, 24'h400000, 1'b1);

      // Reset in the middle of a calculation.
      @(negedge clk);
      a = 24'h200000;
      b = 24'h400000;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_valid_out", 48'(valid_out), 48'h0);
      check("midrst_p", 48'(p), 48'h0);
      check("midrst_in_ready", 48'(in_ready), 48'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (valid_out) seen++;
      end
      check("no_result_after_reset", 48'(seen), 48'h0);
      run_op(24'h200000, 24'h400000, 1'b1);

      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 7))
            0:       rb = 24'd0;
            1:       rb = 24'($urandom_range(1, 255));
            2:       rb = 24'(-$urandom_range(1, 255));
            default: rb = 24'($urandom);
         endcase
         run_op(24'($urandom), rb, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
